// File: rtl/jt051937_draw.sv
// jt051937_draw: sprite line drawer. Fetches one 16-pixel 4bpp tile row
// (two 32-bit ROM words), applies hflip/vflip and optional horizontal zoom,
// and writes the non-transparent pixels into the sprite line buffer.
// Optional feature macro: JT051937_HZOOM_EN (fractional hzoom with phase carry).
module jt051937_draw (
  input  logic        rst,
  input  logic        clk,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic [1:0]  shd,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [9:0]  hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [15:0] buf_din
);

  localparam int unsigned XW   = 9;
  localparam int unsigned CNTW = 8;
`ifdef JT051937_HZOOM_EN
  localparam int unsigned ACCW = 11;
  localparam int unsigned ZW   = 10;
`endif

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

  state_t            state_q, state_d;
  logic [15:0]       code_q, code_d;
  logic [3:0]        row_q, row_d;
  logic [9:0]        attr_q, attr_d;
  logic [1:0]        shd_q, shd_d;
  logic              hflip_q, hflip_d;
  logic [63:0]       gfx_q, gfx_d;
  logic [XW-1:0]     xcur_q, xcur_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [3:0]        src;
  logic [3:0]        pix;
  logic              rom_cs_d;

  logic              busy_q, rom_cs_q, buf_we_q;
  logic [20:0]       rom_addr_q;
  logic [XW-1:0]     buf_addr_q;
  logic [15:0]       buf_din_q;

`ifdef JT051937_HZOOM_EN
  logic [ACCW-1:0]   acc_q, acc_d, acc_sum;
  logic [ZW-1:0]     step_q, step_d;
`else
  logic              unused_hzoom;
  assign unused_hzoom = ^hzoom;
`endif

  // Next-state: tile latch, ROM fetch sequencing and per-pixel stepping
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    row_d   = row_q;
    attr_d  = attr_q;
    shd_d   = shd_q;
    hflip_d = hflip_q;
    gfx_d   = gfx_q;
    xcur_d  = xcur_q;
    cnt_d   = cnt_q;
`ifdef JT051937_HZOOM_EN
    step_d  = step_q;
    acc_d   = acc_q;
    acc_sum = acc_q + {1'b0, step_q};
`endif
    case (state_q)
      IDLE: begin
        if (dr_start) begin
          code_d  = code;
          row_d   = ysub ^ {4{vflip}};
          attr_d  = attr;
          shd_d   = shd;
          hflip_d = hflip;
          if (!hz_keep) xcur_d = hpos;
`ifdef JT051937_HZOOM_EN
          step_d = (hzoom == '0) ? ZW'(1) : hzoom;
          if (!hz_keep) acc_d = '0;
`endif
          state_d = FETCH0;
        end
      end
      FETCH0: begin
        if (rom_ok) begin
          gfx_d[63:32] = rom_data;
          state_d      = FETCH1;
        end
      end
      FETCH1: begin
        if (rom_ok) begin
          gfx_d[31:0] = rom_data;
          cnt_d       = '0;
          state_d     = DRAW;
        end
      end
      DRAW: begin
        xcur_d = xcur_q + XW'(1);
        cnt_d  = cnt_q + CNTW'(1);
`ifdef JT051937_HZOOM_EN
        acc_d = acc_sum;
        if (acc_sum[10]) begin
          acc_d   = {1'b0, acc_sum[9:0]};
          state_d = IDLE;
        end else if (cnt_q == CNTW'(255)) begin
          acc_d   = '0;
          state_d = IDLE;
        end
`else
        if (cnt_q == CNTW'(15)) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel select for the pixel that will be on the buffer port next cycle
  always_comb begin
`ifdef JT051937_HZOOM_EN
    src = acc_d[9:6];
`else
    src = cnt_d[3:0];
`endif
    if (hflip_d) src = ~src;
    pix      = 4'(gfx_d >> (6'd60 - {src, 2'b00}));
    rom_cs_d = (state_d == FETCH0) || (state_d == FETCH1);
  end

  // State, tile context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= '0;
      row_q      <= '0;
      attr_q     <= '0;
      shd_q      <= '0;
      hflip_q    <= 1'b0;
      gfx_q      <= '0;
      xcur_q     <= '0;
      cnt_q      <= '0;
`ifdef JT051937_HZOOM_EN
      acc_q      <= '0;
      step_q     <= '0;
`endif
      busy_q     <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      row_q      <= row_d;
      attr_q     <= attr_d;
      shd_q      <= shd_d;
      hflip_q    <= hflip_d;
      gfx_q      <= gfx_d;
      xcur_q     <= xcur_d;
      cnt_q      <= cnt_d;
`ifdef JT051937_HZOOM_EN
      acc_q      <= acc_d;
      step_q     <= step_d;
`endif
      busy_q     <= (state_d != IDLE);
      rom_cs_q   <= rom_cs_d;
      if (rom_cs_d) rom_addr_q <= {code_d, row_d, (state_d == FETCH1)};
      buf_we_q   <= (state_d == DRAW) && (pix != 4'd0);
      buf_addr_q <= xcur_d;
      buf_din_q  <= {shd_d, attr_d, pix};
    end
  end

  assign dr_busy  = busy_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jt051937_draw.sv
// tb_jt051937_draw: directed and random tiles checked against a pixel-list
// model of the drawer (x position, zoom phase, flips, transparency, timing).
module tb_jt051937_draw;

  logic        rst, clk, dr_start, dr_busy;
  logic [15:0] code;
  logic [9:0]  attr;
  logic [1:0]  shd;
  logic        hflip, vflip, hz_keep;
  logic [8:0]  hpos;
  logic [3:0]  ysub;
  logic [9:0]  hzoom;
  logic [20:0] rom_addr;
  logic        rom_cs, rom_ok, buf_we;
  logic [31:0] rom_data;
  logic [8:0]  buf_addr;
  logic [15:0] buf_din;

  int n_cmp = 0;
  int n_err = 0;
  int m_x;
`ifdef JT051937_HZOOM_EN
  int m_acc;
`endif

  typedef struct {
    int          k;
    logic [8:0]  addr;
    logic [15:0] din;
  } wr_t;
  wr_t exp_q[$];

  jt051937_draw dut (
    .rst(rst), .clk(clk), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .shd(shd), .hflip(hflip), .vflip(vflip),
    .hpos(hpos), .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(dr_busy), 32'd0);
    chk({tag, "_rom_cs"}, 32'(rom_cs), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    chk({tag, "_buf_addr"}, 32'(buf_addr), 32'd0);
    chk({tag, "_buf_din"}, 32'(buf_din), 32'd0);
  endtask

  // Start a tile at the current negedge, serve ROM after d0/d1 wait cycles,
  // check every busy cycle; returns at the first negedge with dr_busy low.
  task automatic run_tile(input logic [15:0] t_code, input logic [9:0] t_attr,
                          input logic [1:0] t_shd, input logic t_hflip, input logic t_vflip,
                          input logic [8:0] t_hpos, input logic [3:0] t_ysub,
                          input logic [9:0] t_hzoom, input logic t_keep,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int d0, input int d1, output int nwr);
    logic [63:0] g;
    logic [3:0]  nib;
    logic [20:0] ra0, ra1;
    int x0, a0, step, npix, pos, s, row, busy_cnt, first, endacc;
    bit done;
    wr_t w;
    g = {w0, w1};
    x0 = t_keep ? m_x : int'(t_hpos);
`ifdef JT051937_HZOOM_EN
    a0   = t_keep ? m_acc : 0;
    step = (t_hzoom == 10'd0) ? 1 : int'(t_hzoom);
`else
    a0   = 0;
    step = 64;
`endif
    exp_q.delete();
    npix = 0;
    endacc = 0;
    while (1) begin
      pos = a0 + npix * step;
      if (pos >= 1024) begin endacc = pos - 1024; break; end
      if (npix == 256) begin endacc = 0; break; end
      s = pos / 64;
      if (t_hflip) s = 15 - s;
      nib = 4'((g >> (60 - 4 * s)) & 64'hF);
      if (nib != 4'd0) begin
        w.k = npix;
        w.addr = 9'((x0 + npix) % 512);
        w.din = {t_shd, t_attr, nib};
        exp_q.push_back(w);
      end
      npix++;
    end
    row = t_vflip ? 15 - int'(t_ysub) : int'(t_ysub);
    ra0 = 21'(int'(t_code) * 32 + row * 2);
    ra1 = ra0 + 21'd1;
    first = 3 + d0 + d1;

    code = t_code; attr = t_attr; shd = t_shd; hflip = t_hflip; vflip = t_vflip;
    hpos = t_hpos; ysub = t_ysub; hzoom = t_hzoom; hz_keep = t_keep;
    rom_ok = 1'b0;
    dr_start = 1'b1;
    done = 0; nwr = 0; busy_cnt = 0;
    for (int i = 1; i <= 600 && !done; i++) begin
      @(negedge clk);
      dr_start = 1'b0;
      if (i == 1) begin
        chk("busy_rise", 32'(dr_busy), 32'd1);
        code = 16'($urandom); attr = 10'($urandom); shd = 2'($urandom);
        hflip = 1'($urandom); vflip = 1'($urandom); hpos = 9'($urandom);
        ysub = 4'($urandom); hzoom = 10'($urandom); hz_keep = 1'($urandom);
      end
      if (!dr_busy) done = 1;
      else begin
        busy_cnt++;
        if (i <= 1 + d0) begin
          chk("fetch0_cs", 32'(rom_cs), 32'd1);
          chk("fetch0_addr", 32'(rom_addr), 32'(ra0));
          rom_ok = (i == 1 + d0);
          rom_data = rom_ok ? w0 : $urandom;
        end else if (i <= 2 + d0 + d1) begin
          chk("fetch1_cs", 32'(rom_cs), 32'd1);
          chk("fetch1_addr", 32'(rom_addr), 32'(ra1));
          rom_ok = (i == 2 + d0 + d1);
          rom_data = rom_ok ? w1 : $urandom;
        end else begin
          chk("draw_cs", 32'(rom_cs), 32'd0);
          rom_ok = 1'($urandom_range(0, 1));
          rom_data = $urandom;
        end
        if (buf_we) begin
          nwr++;
          chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_slot", 32'(i - first), 32'(w.k));
            chk("wr_addr", 32'(buf_addr), 32'(w.addr));
            chk("wr_din", 32'(buf_din), 32'(w.din));
          end
        end
        if ($urandom_range(0, 3) == 0) dr_start = 1'b1;
      end
    end
    rom_ok = 1'b0;
    dr_start = 1'b0;
    chk("busy_done", 32'(done), 32'd1);
    chk("busy_len", 32'(busy_cnt), 32'(2 + d0 + d1 + npix));
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    m_x = (x0 + npix) % 512;
`ifdef JT051937_HZOOM_EN
    m_acc = endacc;
`endif
  endtask

  initial begin
    int nwr;
    rst = 1'b1; dr_start = 1'b0; code = '0; attr = '0; shd = '0; hflip = 1'b0;
    vflip = 1'b0; hpos = '0; ysub = '0; hzoom = '0; hz_keep = 1'b0;
    rom_data = '0; rom_ok = 1'b0;
    m_x = 0;
`ifdef JT051937_HZOOM_EN
    m_acc = 0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Stale ROM acknowledges while idle
    for (int i = 0; i < 3; i++) begin
      rom_ok = 1'b1; rom_data = $urandom;
      @(negedge clk);
      chk("stale_busy", 32'(dr_busy), 32'd0);
      chk("stale_we", 32'(buf_we), 32'd0);
    end
    rom_ok = 1'b0;

    // 1:1 draw, then flipped, then stalled ROM (back-to-back starts)
    run_tile(16'h1234, 10'h155, 2'd2, 1'b0, 1'b0, 9'h020, 4'd5, 10'h40, 1'b0,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("plain_writes", 32'(nwr), 32'd15);
    run_tile(16'h1234, 10'h2AA, 2'd1, 1'b1, 1'b1, 9'h020, 4'd5, 10'h40, 1'b0,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("flip_writes", 32'(nwr), 32'd15);
    run_tile(16'hBEEF, 10'h0F0, 2'd3, 1'b0, 1'b1, 9'h100, 4'd3, 10'h40, 1'b0,
             $urandom, $urandom, 5, 5, nwr);

    // x wrap, then continuation of x into the next tile
    run_tile(16'h0042, 10'h3FF, 2'd0, 1'b0, 1'b0, 9'h1FE, 4'd0, 10'h40, 1'b0,
             32'h11111111, 32'h22222222, 0, 1, nwr);
    run_tile(16'h0043, 10'h001, 2'd1, 1'b1, 1'b0, 9'h0AA, 4'd9, 10'h40, 1'b1,
             32'h33333333, 32'h44444444, 1, 0, nwr);
    chk("keep_x", 32'(m_x), 32'd30);

`ifdef JT051937_HZOOM_EN
    run_tile(16'h0100, 10'h010, 2'd0, 1'b0, 1'b0, 9'h040, 4'd1, 10'h80, 1'b0,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("shrink_writes", 32'(nwr), 32'd8);
    run_tile(16'h0101, 10'h011, 2'd0, 1'b0, 1'b0, 9'h000, 4'd1, 10'h80, 1'b1,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("shrink_keep_x", 32'(m_x), 32'h050);
    run_tile(16'h0102, 10'h012, 2'd1, 1'b0, 1'b0, 9'h080, 4'd2, 10'h60, 1'b0,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("carry_rem", 32'(m_acc), 32'h20);
    run_tile(16'h0103, 10'h013, 2'd1, 1'b1, 1'b0, 9'h000, 4'd2, 10'h60, 1'b1,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    run_tile(16'h0104, 10'h014, 2'd2, 1'b0, 1'b0, 9'h010, 4'd4, 10'h000, 1'b0,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("abort_writes", 32'(nwr), 32'd256);
`else
    run_tile(16'h0100, 10'h010, 2'd0, 1'b0, 1'b0, 9'h040, 4'd1, 10'h80, 1'b0,
             32'h12345678, 32'h9ABCDEF0, 0, 0, nwr);
    chk("nozoom_writes", 32'(nwr), 32'd15);
`endif

    // Reset in the middle of DRAW
    code = 16'h5555; attr = 10'h100; shd = 2'd1; hflip = 1'b0; vflip = 1'b0;
    hpos = 9'h0C0; ysub = 4'd7; hzoom = 10'h40; hz_keep = 1'b0;
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0; rom_ok = 1'b1; rom_data = 32'h12345678;
    @(negedge clk);
    rom_data = 32'h9ABCDEF0;
    @(negedge clk);
    rom_ok = 1'b0;
    chk("mid_we", 32'(buf_we), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    chk_all_zero("mid_hold");
    rst = 1'b0;
    m_x = 0;
`ifdef JT051937_HZOOM_EN
    m_acc = 0;
`endif
    run_tile(16'h0777, 10'h077, 2'd3, 1'b0, 1'b0, 9'h1AB, 4'd6, 10'h40, 1'b1,
             32'hFEDCBA98, 32'h76543210, 0, 0, nwr);

    // Random tiles
    for (int t = 0; t < 20; t++) begin
      run_tile(16'($urandom), 10'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               9'($urandom), 4'($urandom), 10'($urandom_range(16, 1023)), 1'($urandom),
               $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), nwr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
